// File: rtl/sd_spi_pkg.sv
// Shared constants, state/error encodings and the command frame builder for the SD command sequencer.
package sd_spi_pkg;

   localparam logic [47:0] DUMMY_FRAME       = 48'hFFFF_FFFF_FFFF;
   localparam logic [7:0]  TOKEN_START_BLOCK = 8'hFE;

   localparam logic [5:0]  CMD0  = 6'd0;
   localparam logic [5:0]  CMD17 = 6'd17;
   localparam logic [5:0]  CMD24 = 6'd24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_CMD,
      S_POLL_R1,
      S_POLL_TOKEN,
      S_GET_DATA,
      S_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      ERR_OK            = 2'd0,
      ERR_R1_TIMEOUT    = 2'd1,
      ERR_R1_BITS       = 2'd2,
      ERR_TOKEN_TIMEOUT = 2'd3
   } seq_err_t;

   function automatic logic [47:0] build_frame(input logic [5:0]  idx,
                                               input logic [31:0] arg,
                                               input logic [7:0]  crc);
      return {2'b01, idx, arg, crc};
   endfunction

endpackage

// File: rtl/spi_frame_xfer.sv
// One-frame handshake with spi_master: single-cycle start pulse, then waits for done,
// accepting it only after it has been observed low so a level-style done is never counted twice.
module spi_frame_xfer
   import sd_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [47:0] frame,
   input  logic [47:0] spi_rdata,
   input  logic        spi_done,
   output logic        spi_start,
   output logic [47:0] spi_wdata,
   output logic        done,
   output logic [47:0] rdata
);

   typedef enum logic [1:0] {X_IDLE, X_START, X_WAIT} xfer_state_t;

   xfer_state_t st;
   logic        seen_low;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= X_IDLE;
         spi_start <= 1'b0;
         spi_wdata <= DUMMY_FRAME;
         done      <= 1'b0;
         rdata     <= DUMMY_FRAME;
         seen_low  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (st)
            X_IDLE: begin
               if (go) begin
                  spi_wdata <= frame;
                  spi_start <= 1'b1;
                  seen_low  <= 1'b0;
                  st        <= X_START;
               end
            end
            X_START: begin
               spi_start <= 1'b0;
               seen_low  <= !spi_done;
               st        <= X_WAIT;
            end
            X_WAIT: begin
               // done still high from the previous frame must drop before it counts again
               if (spi_done && seen_low) begin
                  rdata <= spi_rdata;
                  done  <= 1'b1;
                  st    <= X_IDLE;
               end else if (!spi_done) begin
                  seen_low <= 1'b1;
               end
            end
            default: st <= X_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Sends one SD command frame, polls for R1 and, for data commands, the start token and the data block.
module sd_cmd_sequencer
   import sd_spi_pkg::*;
#(
   parameter int          MAX_POLL = 16,
   parameter logic [7:0]  CRC_BYTE = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_idx,
   input  logic [31:0] req_arg,
   input  logic        req_has_data,
   output logic        spi_start,
   output logic [47:0] spi_wdata,
   input  logic [47:0] spi_rdata,
   input  logic        spi_done,
   output logic        resp_valid,
   output logic [7:0]  resp_r1,
   output logic [47:0] resp_data,
   output logic        resp_data_valid,
   output logic [1:0]  resp_err
);

   localparam int CNT_W = $clog2(MAX_POLL + 1);

   seq_state_t        state;
   logic [5:0]        idx_q;
   logic [31:0]       arg_q;
   logic              has_data_q;
   logic [CNT_W-1:0]  poll_cnt;
   logic [CNT_W-1:0]  poll_inc;
   logic              poll_last;
   logic              launch;
   logic [47:0]       xfer_frame;
   logic              xfer_done;
   logic [47:0]       xfer_rdata;

   assign xfer_frame = (state == S_SEND_CMD) ? build_frame(idx_q, arg_q, CRC_BYTE) : DUMMY_FRAME;
   assign poll_inc   = poll_cnt + 1'b1;
   assign poll_last  = (poll_inc == CNT_W'(MAX_POLL));

   spi_frame_xfer u_xfer (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (launch),
      .frame     (xfer_frame),
      .spi_rdata (spi_rdata),
      .spi_done  (spi_done),
      .spi_start (spi_start),
      .spi_wdata (spi_wdata),
      .done      (xfer_done),
      .rdata     (xfer_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         idx_q           <= '0;
         arg_q           <= '0;
         has_data_q      <= 1'b0;
         poll_cnt        <= '0;
         launch          <= 1'b0;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_r1         <= '0;
         resp_data       <= '0;
         resp_data_valid <= 1'b0;
         resp_err        <= ERR_OK;
      end else begin
         launch     <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  idx_q           <= req_idx;
                  arg_q           <= req_arg;
                  has_data_q      <= req_has_data;
                  poll_cnt        <= '0;
                  req_ready       <= 1'b0;
                  resp_r1         <= '0;
                  resp_data       <= '0;
                  resp_data_valid <= 1'b0;
                  resp_err        <= ERR_OK;
                  launch          <= 1'b1;
                  state           <= S_SEND_CMD;
               end
            end
            S_SEND_CMD: begin
               if (xfer_done) begin
                  launch <= 1'b1;
                  state  <= S_POLL_R1;
               end
            end
            S_POLL_R1: begin
               if (xfer_done) begin
                  if (xfer_rdata != DUMMY_FRAME) begin
                     resp_r1 <= xfer_rdata[7:0];
                     if (xfer_rdata[7:1] != 7'd0) begin
                        resp_err   <= ERR_R1_BITS;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                     end else if (has_data_q) begin
                        poll_cnt <= '0;
                        launch   <= 1'b1;
                        state    <= S_POLL_TOKEN;
                     end else begin
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                     end
                  end else if (poll_last) begin
                     resp_err   <= ERR_R1_TIMEOUT;
                     resp_valid <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     poll_cnt <= poll_inc;
                     launch   <= 1'b1;
                  end
               end
            end
            S_POLL_TOKEN: begin
               if (xfer_done) begin
                  if (xfer_rdata[7:0] == TOKEN_START_BLOCK) begin
                     launch <= 1'b1;
                     state  <= S_GET_DATA;
                  end else if (poll_last) begin
                     resp_err   <= ERR_TOKEN_TIMEOUT;
                     resp_valid <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     poll_cnt <= poll_inc;
                     launch   <= 1'b1;
                  end
               end
            end
            S_GET_DATA: begin
               // an all-ones block cannot be told apart from idle bus, so this state has no timeout
               if (xfer_done) begin
                  if (xfer_rdata != DUMMY_FRAME) begin
                     resp_data       <= xfer_rdata;
                     resp_data_valid <= 1'b1;
                     resp_valid      <= 1'b1;
                     state           <= S_DONE;
                  end else begin
                     launch <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Table-driven bench for sd_cmd_sequencer with a scripted per-frame SPI master/slave stub.
module tb_sd_cmd_sequencer;

   localparam logic [47:0] DUMMY = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_idx;
   logic [31:0] req_arg;
   logic        req_has_data;
   logic        spi_start;
   logic [47:0] spi_wdata;
   logic [47:0] spi_rdata;
   logic        spi_done;
   logic        resp_valid;
   logic [7:0]  resp_r1;
   logic [47:0] resp_data;
   logic        resp_data_valid;
   logic [1:0]  resp_err;

   sd_cmd_sequencer #(.MAX_POLL(16), .CRC_BYTE(8'hFF)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_idx         (req_idx),
      .req_arg         (req_arg),
      .req_has_data    (req_has_data),
      .spi_start       (spi_start),
      .spi_wdata       (spi_wdata),
      .spi_rdata       (spi_rdata),
      .spi_done        (spi_done),
      .resp_valid      (resp_valid),
      .resp_r1         (resp_r1),
      .resp_data       (resp_data),
      .resp_data_valid (resp_data_valid),
      .resp_err        (resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic        hd;
      logic        lvl;
      logic [7:0]  r1;
      logic [1:0]  err;
      logic        dv;
      logic [47:0] data;
      int          frames;
      logic [47:0] frame;
   } vec_t;

   localparam int NV = 7;
   vec_t        tbl [NV];
   logic [47:0] scr_tbl [NV][20];
   int          scr_n [NV];

   // stub script, owned by the main process
   logic [47:0] cur_scr [20];
   int          cur_len;
   logic        cur_lvl;
   int          load_id;

   // stub state, owned by the stub process
   int          last_id;
   int          ptr;
   int          frames;
   int          bad_dummy;
   logic [47:0] first_wdata;
   logic        busy;
   logic        lower_pend;
   int          timer;

   int n_cmp;
   int n_err;

   function automatic logic [47:0] b(input logic [7:0] v);
      return {40'hFF_FFFF_FFFF, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int k, input logic [5:0] idx, input logic [31:0] arg,
                          input logic hd, input logic lvl, input logic [7:0] r1,
                          input logic [1:0] err, input logic dv, input logic [47:0] data,
                          input int fr, input logic [47:0] frame);
      tbl[k].idx = idx;  tbl[k].arg = arg;  tbl[k].hd = hd;  tbl[k].lvl = lvl;
      tbl[k].r1 = r1;    tbl[k].err = err;  tbl[k].dv = dv;  tbl[k].data = data;
      tbl[k].frames = fr; tbl[k].frame = frame;
      scr_n[k] = 0;
   endtask

   task automatic add(input int k, input logic [47:0] v);
      scr_tbl[k][scr_n[k]] = v;
      scr_n[k]++;
   endtask

   task automatic load(input int k);
      for (int i = 0; i < 20; i++) cur_scr[i] = scr_tbl[k][i];
      cur_len = scr_n[k];
      cur_lvl = tbl[k].lvl;
      load_id++;
      tick();
      tick();
   endtask

   task automatic request(input logic [5:0] idx, input logic [31:0] arg, input logic hd);
      req_valid    = 1'b1;
      req_idx      = idx;
      req_arg      = arg;
      req_has_data = hd;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input int k);
      bit got;
      string tag;
      tag = $sformatf("v%0d", k);
      load(k);
      request(tbl[k].idx, tbl[k].arg, tbl[k].hd);
      got = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         if (resp_valid) got = 1'b1;
         else tick();
      end
      chk({tag, "_resp_seen"}, 48'(got), 48'd1);
      chk({tag, "_r1"},     48'(resp_r1), 48'(tbl[k].r1));
      chk({tag, "_err"},    48'(resp_err), 48'(tbl[k].err));
      chk({tag, "_dv"},     48'(resp_data_valid), 48'(tbl[k].dv));
      chk({tag, "_data"},   resp_data, tbl[k].data);
      chk({tag, "_frames"}, 48'(frames), 48'(tbl[k].frames));
      chk({tag, "_cmd"},    first_wdata, tbl[k].frame);
      chk({tag, "_dummy"},  48'(bad_dummy), 48'd0);
      tick();
      chk({tag, "_pulse"},  48'(resp_valid), 48'd0);
      chk({tag, "_ready"},  48'(req_ready), 48'd1);
   endtask

   // behavioural spi_master + SD card: 3-cycle frame, responses taken from the script
   initial begin
      spi_done = 1'b0; spi_rdata = DUMMY; busy = 1'b0; lower_pend = 1'b0;
      last_id = 0; ptr = 0; frames = 0; bad_dummy = 0; first_wdata = '0; timer = 0;
      forever begin
         tick();
         if (load_id != last_id) begin
            last_id = load_id; ptr = 0; frames = 0; bad_dummy = 0; first_wdata = '0;
            spi_done = 1'b0;
         end
         if (!rst_n) begin
            busy = 1'b0; lower_pend = 1'b0; spi_done = 1'b0; spi_rdata = DUMMY;
         end else begin
            if (lower_pend) begin
               spi_done   = 1'b0;
               lower_pend = 1'b0;
            end
            if (spi_start) begin
               if (frames == 0) first_wdata = spi_wdata;
               else if (spi_wdata !== DUMMY) bad_dummy++;
               frames++;
               busy  = 1'b1;
               timer = 3;
               if (cur_lvl) lower_pend = 1'b1;
               else spi_done = 1'b0;
            end else if (busy) begin
               timer--;
               if (timer == 0) begin
                  spi_rdata = (ptr < cur_len) ? cur_scr[ptr] : DUMMY;
                  ptr++;
                  spi_done = 1'b1;
                  busy     = 1'b0;
               end
            end else if (!cur_lvl) begin
               spi_done = 1'b0;
            end
         end
      end
   end

   initial begin
      bit hit;
      n_cmp = 0; n_err = 0; load_id = 0; cur_len = 0; cur_lvl = 1'b0;
      for (int i = 0; i < 20; i++) cur_scr[i] = DUMMY;
      rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_arg = '0; req_has_data = 1'b0;

      set_vec(0, 6'd17, 32'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 48'h0, 3, 48'h51_0000_0000_FF);
      add(0, b(8'hFF)); add(0, b(8'hFF)); add(0, b(8'h00));
      set_vec(1, 6'd17, 32'h0000_0200, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 48'hCAFE_BABE_5678, 7,
              48'h51_0000_0200_FF);
      add(1, b(8'hFF)); add(1, b(8'hFF)); add(1, b(8'h00));
      add(1, b(8'hFF)); add(1, b(8'hFE));
      add(1, b(8'hFF)); add(1, 48'hCAFE_BABE_5678);
      set_vec(2, 6'd24, 32'h1234_5678, 1'b1, 1'b0, 8'h04, 2'd2, 1'b0, 48'h0, 3, 48'h58_1234_5678_FF);
      add(2, b(8'hFF)); add(2, b(8'hFF)); add(2, b(8'h04));
      set_vec(3, 6'd0, 32'h0, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 48'h0, 17, 48'h40_0000_0000_FF);
      set_vec(4, 6'd17, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'h00, 2'd3, 1'b0, 48'h0, 18, 48'h51_DEAD_BEEF_FF);
      add(4, b(8'hFF)); add(4, b(8'h00));
      set_vec(5, 6'd8, 32'h0000_01AA, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0, 48'h0, 2, 48'h48_0000_01AA_FF);
      add(5, b(8'hFF)); add(5, b(8'h01));
      set_vec(6, 6'd17, 32'h0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 48'h0, 17, 48'h51_0000_0000_FF);
      for (int i = 0; i < 16; i++) add(6, DUMMY);
      add(6, b(8'h00));

      tick(); tick();
      chk("rst_ready", 48'(req_ready), 48'd1);
      chk("rst_start", 48'(spi_start), 48'd0);
      chk("rst_wdata", spi_wdata, DUMMY);
      chk("rst_resp",  {44'd0, resp_valid, resp_data_valid, resp_err}, 48'd0);
      chk("rst_r1",    48'(resp_r1), 48'd0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < NV; k++) run_vec(k);

      // busy requests are ignored, then reset lands while polling for R1
      load(3);
      request(6'd17, 32'h0, 1'b0);
      req_valid = 1'b1; req_idx = 6'd24; req_arg = 32'h5555_5555;
      tick(); tick(); tick();
      chk("busy_ready", 48'(req_ready), 48'd0);
      req_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (frames >= 3) hit = 1'b1;
         else tick();
      end
      chk("reach_poll", 48'(hit), 48'd1);
      chk("busy_cmd",   first_wdata, 48'h51_0000_0000_FF);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_start", 48'(spi_start), 48'd0);
      chk("mid_rst_valid", 48'(resp_valid), 48'd0);
      chk("mid_rst_ready", 48'(req_ready), 48'd1);
      chk("mid_rst_err",   48'(resp_err), 48'd0);
      rst_n = 1'b1;
      tick();
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
